// File: rtl/exception_ctrl.sv
// Exception entry/return sequencer for the LEGv8 core: arbitrates NotAnInstr, ERet and ExtIRQ.
// Latency: exception seen in IDLE -> pc_sel=01 exactly FLUSH_CYCLES+1 cycles later (+2 for IRQ with sync).
// Backpressure: none; holds the fetch stage via stall/flush while sequencing, masks IRQ in the handler.
//
// Ports:
//   clk, reset          core clock, synchronous active-high reset
//   ExtIRQ              external interrupt request (level)
//   NotAnInstr, EStatus decoder: undefined opcode and its status code
//   ERet                decoder: ERET in decode
//   pc_cur              PC of the instruction in decode
//   ELR, ESR, ERR       exception link / syndrome / return registers (MRS sources)
//   pc_sel              00 normal, 01 vector, 10 ERR
//   flush, stall        pipeline squash / freeze
//   irq_ack             one-cycle pulse when an IRQ vector is taken
//   in_handler          handler running, IRQ masked
//   double_fault        sticky fatal fault
//
// Optional feature macro: EXC_IRQ_SYNC_EN (2-flop synchronizer on ExtIRQ).
module exception_ctrl #(
    parameter int          N            = 64,
    parameter logic [63:0] VECTOR_ADDR  = 64'hD8,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ExtIRQ,
    input  logic         NotAnInstr,
    input  logic [3:0]   EStatus,
    input  logic         ERet,
    input  logic [N-1:0] pc_cur,
    output logic [N-1:0] ELR,
    output logic [3:0]   ESR,
    output logic [N-1:0] ERR,
    output logic [1:0]   pc_sel,
    output logic         flush,
    output logic         stall,
    output logic         irq_ack,
    output logic         in_handler,
    output logic         double_fault
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [3:0] ESR_IRQ    = 4'b0001;
    localparam logic [3:0] ESR_ERET   = 4'b0100;
    localparam logic [3:0] ESR_DFAULT = 4'b1111;

    // The vector itself is applied by the fetch-stage mux; these checks catch bad builds early.
    if (FLUSH_CYCLES < 1) begin : g_bad_flush
        $error("exception_ctrl: FLUSH_CYCLES must be >= 1");
    end
    if (VECTOR_ADDR[1:0] != 2'b00) begin : g_bad_vector
        $error("exception_ctrl: VECTOR_ADDR must be word aligned");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FLUSH   = 3'd1,
        VECTOR  = 3'd2,
        HANDLER = 3'd3,
        RETURN  = 3'd4,
        HALT    = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   elr_q, elr_d;
    logic [N-1:0]   err_q, err_d;
    logic [3:0]     esr_q, esr_d;
    logic           irq_use;

`ifdef EXC_IRQ_SYNC_EN
    // Two-stage synchronizer; IRQ is seen two cycles late, NotAnInstr is not delayed.
    logic irq_s1_q, irq_s1_d;
    logic irq_s2_q, irq_s2_d;

    always_comb begin
        irq_s1_d = ExtIRQ;
        irq_s2_d = irq_s1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_s1_q <= 1'b0;
            irq_s2_q <= 1'b0;
        end else begin
            irq_s1_q <= irq_s1_d;
            irq_s2_q <= irq_s2_d;
        end
    end

    assign irq_use = irq_s2_q;
`else
    assign irq_use = ExtIRQ;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        elr_d        = elr_q;
        err_d        = err_q;
        esr_d        = esr_q;
        pc_sel       = 2'b00;
        flush        = 1'b0;
        stall        = 1'b0;
        irq_ack      = 1'b0;
        in_handler   = 1'b0;
        double_fault = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (NotAnInstr || ERet || irq_use) begin
                    if (NotAnInstr) begin
                        esr_d = EStatus;
                    end else if (ERet) begin
                        esr_d = ESR_ERET;      // ERET with no handler active is illegal
                    end else begin
                        esr_d = ESR_IRQ;
                    end
                    elr_d   = pc_cur;
                    err_d   = pc_cur + N'(4);  // wraps mod 2^N
                    cnt_d   = CW'(FLUSH_CYCLES - 1);
                    state_d = FLUSH;
                    // Squash the excepting instruction in the same cycle it is seen.
                    flush   = 1'b1;
                    stall   = 1'b1;
                end
            end
            FLUSH: begin
                flush = 1'b1;
                stall = 1'b1;
                if (cnt_q == '0) begin
                    state_d = VECTOR;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            VECTOR: begin
                pc_sel  = 2'b01;
                flush   = 1'b1;
                irq_ack = (esr_q == ESR_IRQ);
                state_d = HANDLER;
            end
            HANDLER: begin
                in_handler = 1'b1;
                if (NotAnInstr) begin
                    // Fault inside the handler: ELR/ERR kept for post-mortem.
                    esr_d   = ESR_DFAULT;
                    state_d = HALT;
                end else if (ERet) begin
                    state_d = RETURN;
                end
            end
            RETURN: begin
                pc_sel     = 2'b10;
                flush      = 1'b1;
                in_handler = 1'b1;
                state_d    = IDLE;
            end
            HALT: begin
                double_fault = 1'b1;
                stall        = 1'b1;
                flush        = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            elr_q   <= '0;
            err_q   <= '0;
            esr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            elr_q   <= elr_d;
            err_q   <= err_d;
            esr_q   <= esr_d;
        end
    end

    assign ELR = elr_q;
    assign ERR = err_q;
    assign ESR = esr_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed table-driven bench for exception_ctrl (default build: N=64, FLUSH_CYCLES=2).
// Each row: inputs held for one cycle, outputs compared mid-cycle before the next clock edge.
// Hand sequences cover vector latency and double-fault stickiness.
module tb_exception_ctrl;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         ExtIRQ;
    logic         NotAnInstr;
    logic [3:0]   EStatus;
    logic         ERet;
    logic [N-1:0] pc_cur;
    logic [N-1:0] ELR;
    logic [3:0]   ESR;
    logic [N-1:0] ERR;
    logic [1:0]   pc_sel;
    logic         flush;
    logic         stall;
    logic         irq_ack;
    logic         in_handler;
    logic         double_fault;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    exception_ctrl #(.N(N), .VECTOR_ADDR(64'hD8), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .ExtIRQ(ExtIRQ), .NotAnInstr(NotAnInstr),
        .EStatus(EStatus), .ERet(ERet), .pc_cur(pc_cur), .ELR(ELR), .ESR(ESR),
        .ERR(ERR), .pc_sel(pc_sel), .flush(flush), .stall(stall), .irq_ack(irq_ack),
        .in_handler(in_handler), .double_fault(double_fault)
    );

    typedef struct {
        logic         rst, irq, nai;
        logic [3:0]   est;
        logic         eret;
        logic [N-1:0] pc;
        logic [N-1:0] elr;
        logic [3:0]   esr;
        logic [N-1:0] err;
        logic [1:0]   pcs;
        logic         fl, st, ack, inh, df;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic irq, input logic nai, input logic [3:0] est,
                       input logic eret, input logic [N-1:0] pc,
                       input logic [N-1:0] elr, input logic [3:0] esr, input logic [N-1:0] err,
                       input logic [1:0] pcs, input logic fl, input logic st, input logic ack,
                       input logic inh, input logic df);
        vec_t v;
        v.rst = rst; v.irq = irq; v.nai = nai; v.est = est; v.eret = eret; v.pc = pc;
        v.elr = elr; v.esr = esr; v.err = err; v.pcs = pcs;
        v.fl = fl; v.st = st; v.ack = ack; v.inh = inh; v.df = df;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [N-1:0] ones;
        logic [2*N+4+7-1:0] act_v, exp_v;
        int lat;
        logic seen_ack;

        ones = '1;
        // rst irq nai est eret pc          | elr   esr err   pcs fl st ack inh df
        add(0,0,0,4'd0,0,64'h0,              64'h0,  4'd0,64'h0,  2'd0,0,0,0,0,0); // 0 reset state
        // NotAnInstr, EStatus=2, pc=0x40
        add(0,0,1,4'd2,0,64'h40,             64'h0,  4'd0,64'h0,  2'd0,1,1,0,0,0); // 1 IDLE take
        add(0,0,0,4'd0,0,64'h0,              64'h40, 4'd2,64'h44, 2'd0,1,1,0,0,0); // 2 FLUSH
        add(0,0,0,4'd0,0,64'h0,              64'h40, 4'd2,64'h44, 2'd0,1,1,0,0,0); // 3 FLUSH
        add(0,0,0,4'd0,0,64'h0,              64'h40, 4'd2,64'h44, 2'd1,1,0,0,0,0); // 4 VECTOR
        add(0,0,0,4'd0,0,64'h0,              64'h40, 4'd2,64'h44, 2'd0,0,0,0,1,0); // 5 HANDLER
        add(0,0,0,4'd0,1,64'h0,              64'h40, 4'd2,64'h44, 2'd0,0,0,0,1,0); // 6 HANDLER+ERET
        add(0,0,0,4'd0,0,64'h0,              64'h40, 4'd2,64'h44, 2'd2,1,0,0,1,0); // 7 RETURN
        add(0,0,0,4'd0,0,64'h0,              64'h40, 4'd2,64'h44, 2'd0,0,0,0,0,0); // 8 IDLE
        // ExtIRQ, pc=0x100; masked pulse in handler is dropped
        add(0,1,0,4'd0,0,64'h100,            64'h40, 4'd2,64'h44, 2'd0,1,1,0,0,0); // 9
        add(0,0,0,4'd0,0,64'h0,              64'h100,4'd1,64'h104,2'd0,1,1,0,0,0); // 10
        add(0,0,0,4'd0,0,64'h0,              64'h100,4'd1,64'h104,2'd0,1,1,0,0,0); // 11
        add(0,0,0,4'd0,0,64'h0,              64'h100,4'd1,64'h104,2'd1,1,0,1,0,0); // 12 ack
        add(0,1,0,4'd0,1,64'h0,              64'h100,4'd1,64'h104,2'd0,0,0,0,1,0); // 13
        add(0,0,0,4'd0,0,64'h0,              64'h100,4'd1,64'h104,2'd2,1,0,0,1,0); // 14
        add(0,0,0,4'd0,0,64'h0,              64'h100,4'd1,64'h104,2'd0,0,0,0,0,0); // 15
        // NotAnInstr wins over ExtIRQ; IRQ held and taken right after return
        add(0,1,1,4'd3,0,64'h200,            64'h100,4'd1,64'h104,2'd0,1,1,0,0,0); // 16
        add(0,1,0,4'd0,0,64'h0,              64'h200,4'd3,64'h204,2'd0,1,1,0,0,0); // 17
        add(0,1,0,4'd0,0,64'h0,              64'h200,4'd3,64'h204,2'd0,1,1,0,0,0); // 18
        add(0,1,0,4'd0,0,64'h0,              64'h200,4'd3,64'h204,2'd1,1,0,0,0,0); // 19 no ack
        add(0,1,0,4'd0,0,64'h0,              64'h200,4'd3,64'h204,2'd0,0,0,0,1,0); // 20
        add(0,1,0,4'd0,1,64'h300,            64'h200,4'd3,64'h204,2'd0,0,0,0,1,0); // 21
        add(0,1,0,4'd0,0,64'h0,              64'h200,4'd3,64'h204,2'd2,1,0,0,1,0); // 22
        add(0,1,0,4'd0,0,64'h208,            64'h200,4'd3,64'h204,2'd0,1,1,0,0,0); // 23 IRQ taken
        add(0,0,0,4'd0,0,64'h0,              64'h208,4'd1,64'h20C,2'd0,1,1,0,0,0); // 24
        add(0,0,0,4'd0,0,64'h0,              64'h208,4'd1,64'h20C,2'd0,1,1,0,0,0); // 25
        add(0,0,0,4'd0,0,64'h0,              64'h208,4'd1,64'h20C,2'd1,1,0,1,0,0); // 26 single ack
        // Double fault: NotAnInstr beats ERet in HANDLER
        add(0,0,1,4'd5,1,64'h0,              64'h208,4'd1,64'h20C,2'd0,0,0,0,1,0); // 27
        add(0,1,1,4'd0,1,64'h0,              64'h208,4'hF,64'h20C,2'd0,1,1,0,0,1); // 28 HALT
        add(0,0,0,4'd0,0,64'h0,              64'h208,4'hF,64'h20C,2'd0,1,1,0,0,1); // 29
        add(1,0,0,4'd0,0,64'h0,              64'h208,4'hF,64'h20C,2'd0,1,1,0,0,1); // 30 reset
        add(0,0,0,4'd0,0,64'h0,              64'h0,  4'd0,64'h0,  2'd0,0,0,0,0,0); // 31
        // ERet in IDLE is illegal; pc all-ones wraps ERR to 3
        add(0,0,0,4'd0,1,ones,               64'h0,  4'd0,64'h0,  2'd0,1,1,0,0,0); // 32
        add(0,0,0,4'd0,0,64'h0,              ones,   4'd4,64'h3,  2'd0,1,1,0,0,0); // 33
        add(0,0,0,4'd0,0,64'h0,              ones,   4'd4,64'h3,  2'd0,1,1,0,0,0); // 34
        add(0,0,0,4'd0,0,64'h0,              ones,   4'd4,64'h3,  2'd1,1,0,0,0,0); // 35
        add(0,0,0,4'd0,0,64'h0,              ones,   4'd4,64'h3,  2'd0,0,0,0,1,0); // 36
        // Reset in HANDLER, then reset in FLUSH
        add(1,0,0,4'd0,0,64'h0,              ones,   4'd4,64'h3,  2'd0,0,0,0,1,0); // 37
        add(0,0,1,4'd7,0,64'h500,            64'h0,  4'd0,64'h0,  2'd0,1,1,0,0,0); // 38
        add(1,0,0,4'd0,0,64'h0,              64'h500,4'd7,64'h504,2'd0,1,1,0,0,0); // 39
        add(0,0,0,4'd0,0,64'h0,              64'h0,  4'd0,64'h0,  2'd0,0,0,0,0,0); // 40

        reset = 1'b1; ExtIRQ = 1'b0; NotAnInstr = 1'b0; EStatus = 4'd0; ERet = 1'b0; pc_cur = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; ExtIRQ = tbl[i].irq; NotAnInstr = tbl[i].nai;
            EStatus = tbl[i].est; ERet = tbl[i].eret; pc_cur = tbl[i].pc;
            @(negedge clk);
            act_v = {ELR, ESR, ERR, pc_sel, flush, stall, irq_ack, in_handler, double_fault};
            exp_v = {tbl[i].elr, tbl[i].esr, tbl[i].err, tbl[i].pcs, tbl[i].fl, tbl[i].st,
                     tbl[i].ack, tbl[i].inh, tbl[i].df};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL row%0d: got ELR=%h ESR=%h ERR=%h pcs=%b fl%b st%b ack%b inh%b df%b expected ELR=%h ESR=%h ERR=%h pcs=%b fl%b st%b ack%b inh%b df%b",
                         i, ELR, ESR, ERR, pc_sel, flush, stall, irq_ack, in_handler, double_fault,
                         tbl[i].elr, tbl[i].esr, tbl[i].err, tbl[i].pcs, tbl[i].fl, tbl[i].st,
                         tbl[i].ack, tbl[i].inh, tbl[i].df);
            end
            @(posedge clk);
            #1;
        end

        // Latency: NotAnInstr in IDLE -> pc_sel=01 after FLUSH_CYCLES+1 = 3 cycles.
        reset = 1'b0; NotAnInstr = 1'b1; EStatus = 4'd2; pc_cur = 64'h40;
        lat = 0;
        seen_ack = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            NotAnInstr = 1'b0;
            lat++;
            if (irq_ack) seen_ack = 1'b1;
            if (pc_sel == 2'b01) break;
        end
        chk("vector_latency", N'(lat), N'(3));
        chk("no_ack_on_undef", N'(seen_ack), N'(0));
        chk("latency_elr", ELR, 64'h40);
        chk("latency_err", ERR, 64'h44);

        // Now in VECTOR; next cycle HANDLER, fault there, then HALT must stick.
        @(posedge clk);
        #1;
        NotAnInstr = 1'b1;
        @(posedge clk);
        #1;
        NotAnInstr = 1'b0;
        for (int c = 0; c < 5; c++) begin
            ExtIRQ = c[0];
            ERet   = c[1];
            @(negedge clk);
            chk($sformatf("df_sticky%0d", c), N'({double_fault, stall, flush, ESR}), N'({3'b111, 4'hF}));
            @(posedge clk);
            #1;
        end
        chk("df_elr_kept", ELR, 64'h40);
        chk("df_err_kept", ERR, 64'h44);

        ExtIRQ = 1'b0; ERet = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("final_reset", N'({ESR, pc_sel, flush, stall, irq_ack, in_handler, double_fault}), N'(0));
        chk("final_elr", ELR, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
